// File: rtl/dpu_pio_arbiter.sv
// rtl/dpu_pio_arbiter.sv - round-robin arbiter sharing the dpu_top PIO command port
module dpu_pio_arbiter #(
  parameter int N_REQ       = 2,
  parameter int ADDR_BITS   = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_cmd_valid,
  output logic [N_REQ-1:0]           req_cmd_ready,
  input  logic [3*N_REQ-1:0]         req_cmd_type,
  input  logic [ADDR_BITS*N_REQ-1:0] req_cmd_addr,
  input  logic [8*N_REQ-1:0]         req_cmd_data,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           req_rsp_valid,
  output logic [7:0]                 req_rsp_data,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_type,
  output logic [ADDR_BITS-1:0]       cmd_addr,
  output logic [7:0]                 cmd_data,
  input  logic                       cmd_ready,
  input  logic                       rsp_valid,
  input  logic [7:0]                 rsp_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       err_spurious,
  input  logic                       err_clear
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [2:0] TYPE_READ = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    TMO,
    GAP
  } state_t;

  state_t           state;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    lock_owner;
  logic             lock_active;
  logic [TW-1:0]    tmo_cnt;

  logic             lock_keep;
  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [GW-1:0]    win_idx;
  logic [GW-1:0]    cand;

  // A lock only masks other requesters while its owner still holds req_lock
  assign lock_keep = lock_active && req_lock[lock_owner];

  assign busy = (state != IDLE);

  // Eligible set and round-robin winner, searching upward from rr_ptr+1 with wrap
  always_comb begin
    eligible  = req_cmd_valid;
    if (lock_keep) begin
      eligible = req_cmd_valid & (N_REQ'(1) << lock_owner);
    end
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    // descending so the nearest candidate after rr_ptr is assigned last
    for (int k = N_REQ; k >= 1; k--) begin
      cand = GW'((int'(rr_ptr) + k) % N_REQ);
      if (eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Accept and response routing to the current owner; only the owner ever sees a pulse
  always_comb begin
    req_cmd_ready = '0;
    req_rsp_valid = '0;
    req_rsp_data  = rsp_data;
    if (state == ISSUE) begin
      req_cmd_ready[grant_id] = cmd_ready;
    end
    if (state == WAIT_RSP) begin
      req_rsp_valid[grant_id] = rsp_valid;
    end
    if (state == TMO) begin
      req_rsp_valid[grant_id] = 1'b1;
      req_rsp_data            = 8'hEE;
    end
  end

  // Arbitration FSM with registered command, lock, watchdog and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_valid    <= 1'b0;
      cmd_type     <= '0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      grant_id     <= '0;
      rr_ptr       <= GW'(N_REQ - 1);
      lock_active  <= 1'b0;
      lock_owner   <= '0;
      tmo_cnt      <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      // a response can only belong to an outstanding read; anything else is dropped
      err_spurious <= (rsp_valid && (state != WAIT_RSP)) || (err_spurious && !err_clear);
      err_timeout  <= (state == TMO) || (err_timeout && !err_clear);

      case (state)
        IDLE: begin
          if (lock_active && !req_lock[lock_owner]) begin
            lock_active <= 1'b0;
          end
          if (win_found) begin
            cmd_valid <= 1'b1;
            cmd_type  <= req_cmd_type[3*int'(win_idx) +: 3];
            cmd_addr  <= req_cmd_addr[ADDR_BITS*int'(win_idx) +: ADDR_BITS];
            cmd_data  <= req_cmd_data[8*int'(win_idx) +: 8];
            grant_id  <= win_idx;
            rr_ptr    <= win_idx;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid   <= 1'b0;
            lock_active <= req_lock[grant_id];
            lock_owner  <= grant_id;
            tmo_cnt     <= '0;
            state       <= (cmd_type == TYPE_READ) ? WAIT_RSP : GAP;
          end
        end

        WAIT_RSP: begin
          // a response arriving on the last watchdog cycle still counts
          if (rsp_valid) begin
            state <= GAP;
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state <= TMO;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        TMO: begin
          state <= GAP;
        end

        // one dead cycle so a requester's registered valid can drop before resampling
        GAP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
